// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scanner for a 32-bit hex word.
// The shown word changes only at frame boundaries, so one frame never mixes two values.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 4,
    parameter int LZ_BLANK     = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value_i,
    input  logic [7:0]  dp_i,
    input  logic [7:0]  blank_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [7:0]  an_o,
    output logic        frame_o
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LP_TERM  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] LP_GUARD = CW'(GUARD_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [31:0]   r_val_sh;
    logic [7:0]    r_dp_sh;
    logic [7:0]    r_blank_sh;
    logic          r_frame;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_term;
    logic          w_frame_edge;
    logic          w_guard;
    logic [7:0]    w_lz_blank;
    logic [7:0]    w_blank_vec;
    logic          w_digit_off;
    logic [3:0]    w_nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_term       = (r_cnt == LP_TERM);
    assign w_frame_edge = w_term && (r_idx == 3'd7);
    assign w_guard      = (GUARD_CYCLES != 0) && (r_cnt < LP_GUARD);

    // A digit is a leading zero when it and every more significant nibble are zero;
    // digit 0 always stays lit so a zero word still reads "0".
    always_comb begin
        w_lz_blank = 8'h00;
        for (int k = 1; k < 8; k++) begin
            w_lz_blank[k] = (LZ_BLANK != 0) && ((r_val_sh >> (4 * k)) == 32'd0);
        end
    end

    assign w_blank_vec = r_blank_sh | w_lz_blank;
    assign w_digit_off = w_guard || w_blank_vec[r_idx];
    assign w_nib       = r_val_sh[{r_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (w_term) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_val_sh   <= 32'd0;
            r_dp_sh    <= 8'h00;
            r_blank_sh <= 8'h00;
            r_frame    <= 1'b0;
        end else begin
            r_frame <= w_frame_edge;
            if (w_frame_edge) begin
                r_val_sh   <= value_i;
                r_dp_sh    <= dp_i;
                r_blank_sh <= blank_i;
            end
        end
    end

    // Output stage: one cycle behind (cnt, idx), all pins dark during guard or blank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else if (w_digit_off) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(8'h01 << r_idx);
            r_seg <= hex7(w_nib);
            r_dp  <= ~r_dp_sh[r_idx];
        end
    end

    assign an_o    = r_an;
    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver: two instances (LZ_BLANK 0 and 1) against
// an arithmetic model of the scan schedule driven by an edge count since reset.
module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int GD = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] value_i;
    logic [7:0]  dp_i;
    logic [7:0]  blank_i;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [7:0]  an0, an1;
    logic        frm0, frm1;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: edges since reset release plus the word currently displayed
    int          m_k;
    logic [31:0] m_val;
    logic [7:0]  m_dp;
    logic [7:0]  m_blank;
    logic [7:0]  e_an0, e_an1;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_dp0, e_dp1, e_frame;

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD_CYCLES(GD), .LZ_BLANK(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
        .seg_o(seg0), .dp_o(dp0), .an_o(an0), .frame_o(frm0));

    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD_CYCLES(GD), .LZ_BLANK(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
        .seg_o(seg1), .dp_o(dp1), .an_o(an1), .frame_o(frm1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, m_k, obs, exp);
        end
    endtask

    function automatic void model_out(input int lz, output logic [7:0] an,
                                      output logic [6:0] seg, output logic dp);
        int c, d;
        logic [31:0] upper;
        c = m_k % RD;
        d = (m_k / RD) % 8;
        upper = m_val >> (4 * d);
        an  = 8'hFF;
        seg = 7'h7F;
        dp  = 1'b1;
        if (c >= GD && !m_blank[d] && !(lz != 0 && d > 0 && upper == 32'd0)) begin
            an  = ~(8'h01 << d);
            seg = HEX[upper[3:0]];
            dp  = ~m_dp[d];
        end
    endfunction

    task automatic model_reset();
        m_k = 0; m_val = 32'd0; m_dp = 8'h00; m_blank = 8'h00;
        e_an0 = 8'hFF; e_an1 = 8'hFF; e_seg0 = 7'h7F; e_seg1 = 7'h7F;
        e_dp0 = 1'b1; e_dp1 = 1'b1; e_frame = 1'b0;
    endtask

    task automatic model_edge();
        model_out(0, e_an0, e_seg0, e_dp0);
        model_out(1, e_an1, e_seg1, e_dp1);
        e_frame = ((m_k % (8 * RD)) == (8 * RD - 1));
        if (e_frame) begin
            m_val = value_i; m_dp = dp_i; m_blank = blank_i;
        end
        m_k++;
    endtask

    task automatic compare_all();
        chk("an_lz0", an0, e_an0);
        chk("seg_lz0", seg0, e_seg0);
        chk("dp_lz0", dp0, e_dp0);
        chk("frame_lz0", frm0, e_frame);
        chk("an_lz1", an1, e_an1);
        chk("seg_lz1", seg1, e_seg1);
        chk("dp_lz1", dp1, e_dp1);
        chk("frame_lz1", frm1, e_frame);
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n, input bit junk);
        for (int i = 0; i < n; i++) begin
            step();
            if (junk && $urandom_range(0, 7) == 0) value_i = $urandom;
        end
    endtask

    // advance until the model state sits at digit d, count c (state before next edge)
    task automatic run_to(input int d, input int c);
        int guard_n;
        guard_n = 0;
        while (!(((m_k / RD) % 8) == d && (m_k % RD) == c) && guard_n < 16 * RD) begin
            step();
            guard_n++;
        end
        chk("run_to_reached", (((m_k / RD) % 8) == d && (m_k % RD) == c), 1);
    endtask

    initial begin
        reset_n = 1'b0;
        value_i = 32'd0;
        dp_i    = 8'h00;
        blank_i = 8'h00;
        model_reset();

        // reset held: inputs toggle, outputs stay at reset values
        for (int i = 0; i < 4; i++) begin
            value_i = $urandom;
            dp_i    = $urandom;
            step();
        end

        // capture: 89ABCDEF held through the first frame boundary
        value_i = 32'h89ABCDEF;
        dp_i    = 8'h00;
        reset_n = 1'b1;
        run(140, 1'b0);

        // tear-free: change while digit 3 is lit
        run_to(3, 4);
        value_i = 32'h12345678;
        run(150, 1'b0);

        // leading-zero patterns
        value_i = 32'h00000010;
        run(130, 1'b0);
        value_i = 32'h00000000;
        run(130, 1'b0);

        // per-digit blank and decimal point
        value_i = 32'hA5C3F019;
        blank_i = 8'h04;
        dp_i    = 8'h01;
        run(130, 1'b0);

        // randomized words with varying leading zeros and controls
        for (int p = 0; p < 6; p++) begin
            value_i = $urandom >> $urandom_range(0, 31);
            dp_i    = $urandom;
            blank_i = $urandom & $urandom & $urandom;
            run(130, p[0]);
        end

        // mid-frame asynchronous reset during digit 5
        value_i = 32'hFEDCBA98;
        blank_i = 8'h00;
        dp_i    = 8'h20;
        run(130, 1'b0);
        run_to(5, 4);
        reset_n = 1'b0;
        #1;
        chk("async_an0", an0, 8'hFF);
        chk("async_seg0", seg0, 7'h7F);
        chk("async_dp0", dp0, 1'b1);
        chk("async_an1", an1, 8'hFF);
        chk("async_frame", frm0, 1'b0);
        step();
        reset_n = 1'b1;
        value_i = 32'h0000BEEF;
        run(150, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
